// File: rtl/stf_detector_pkg.sv
// Shared types and sizing helpers for the STF detector: FSM states, IQ field width,
// and the running-sum accumulator width rule.
package wavesense_csi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CAPTURE  = 2'd2,
    COOLDOWN = 2'd3
  } stf_state_e;

  localparam int IQ_W = 16;

  // One extra bit beyond log2(window) keeps the add-new/subtract-oldest sum exact.
  function automatic int acc_width(input int term_w, input int window);
    return term_w + $clog2(window) + 1;
  endfunction

endpackage

// File: rtl/stf_detector_if.sv
// AXI-Stream style beat bundle: a beat transfers on a cycle where tvalid && tready;
// the master holds tvalid/tdata/tlast stable until that handshake.
interface stf_detector_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/stf_detector_corr_accum.sv
// Running-window sum over the last WINDOW accepted terms, one sum per lane;
// history and sums start at zero and only move when en_i is high.
module corr_accum
  import wavesense_csi_pkg::*;
#(
  parameter int  TERM_W = 33,
  parameter int  WINDOW = 16,
  parameter int  LANES  = 1,
  localparam int ACC_W  = acc_width(TERM_W, WINDOW)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [LANES-1:0][TERM_W-1:0] term_i,
  output logic [LANES-1:0][ACC_W-1:0]  sum_o
);

  logic [WINDOW-1:0][LANES-1:0][TERM_W-1:0] hist_q;
  logic [LANES-1:0][ACC_W-1:0]              sum_q, sum_d;

  // Two's-complement wraparound in ACC_W bits is exact because the true sum always fits.
  always_comb begin
    sum_d = sum_q;
    for (int l = 0; l < LANES; l++) begin
      sum_d[l] = sum_q[l] + ACC_W'($signed(term_i[l]))
                          - ACC_W'($signed(hist_q[WINDOW-1][l]));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '0;
      sum_q  <= '0;
    end else if (en_i) begin
      hist_q <= {hist_q[WINDOW-2:0], term_i};
      sum_q  <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/stf_detector.sv
// Short-training-field detector: lag-correlation vs power test, hold-off FSM and frame capture.
// Optional STF_DETECTOR_STATS_EN adds det_count/drop_count outputs.
module stf_detector
  import wavesense_csi_pkg::*;
#(
  parameter int WINDOW      = 16,
  parameter int LAG         = 16,
  parameter int THRESH_Q4   = 12,
  parameter int HOLD        = 32,
  parameter int CAPTURE_LEN = 320,
  parameter int HOLDOFF     = 160,
  parameter int MIN_POWER   = 1_000_000
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_areset,
  stf_detector_if.slave        s00_axis,
  stf_detector_if.master       m00_axis,
  output logic                 detect,
`ifdef STF_DETECTOR_STATS_EN
  output logic [15:0]          det_count,
  output logic [15:0]          drop_count,
`endif
  output stf_state_e           state_o
);

  localparam int PROD_W = 2 * IQ_W;
  localparam int TERM_W = 2 * IQ_W + 1;
  localparam int ACC_W  = acc_width(TERM_W, WINDOW);
  localparam int CMP_W  = ACC_W + 6;
  localparam int RUN_W  = $clog2(HOLD + 1);
  localparam int CNT_W  = $clog2(((CAPTURE_LEN > HOLDOFF) ? CAPTURE_LEN : HOLDOFF) + 1);

  logic                     clk, rst;
  logic                     s_ready, s_acc, above, load, last, det_d;
  logic [LAG-1:0][31:0]     dly_q;
  logic signed [IQ_W-1:0]   r_i, r_q, d_i, d_q;
  logic signed [PROD_W-1:0] m_ii, m_qq, m_qi, m_iq, m_rr, m_ss;
  logic [1:0][TERM_W-1:0]   c_term;
  logic [0:0][TERM_W-1:0]   p_term;
  logic [1:0][ACC_W-1:0]    c_sum;
  logic [0:0][ACC_W-1:0]    p_sum;
  logic [ACC_W-1:0]         mag_re, mag_im;
  logic [CMP_W-1:0]         lhs, rhs;
  stf_state_e               state_q, state_d;
  logic [RUN_W-1:0]         run_q, run_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     detect_q, m_valid_q, m_last_q;
  logic [31:0]              m_data_q;

  assign clk = s00_axis_aclk;
  assign rst = s00_axis_areset;

  assign s_ready = ~rst & ((state_q != CAPTURE) | m00_axis.tready | ~m_valid_q);
  assign s_acc   = s00_axis.tvalid & s_ready;

  always_ff @(posedge clk) begin
    if (rst) dly_q <= '0;
    else if (s_acc) dly_q <= {dly_q[LAG-2:0], s00_axis.tdata};
  end

  assign r_i = s00_axis.tdata[31:16];
  assign r_q = s00_axis.tdata[15:0];
  assign d_i = dly_q[LAG-1][31:16];
  assign d_q = dly_q[LAG-1][15:0];

  // r * conj(d): Re = ri*di + rq*dq, Im = rq*di - ri*dq
  assign m_ii = PROD_W'(r_i) * PROD_W'(d_i);
  assign m_qq = PROD_W'(r_q) * PROD_W'(d_q);
  assign m_qi = PROD_W'(r_q) * PROD_W'(d_i);
  assign m_iq = PROD_W'(r_i) * PROD_W'(d_q);
  assign m_rr = PROD_W'(r_i) * PROD_W'(r_i);
  assign m_ss = PROD_W'(r_q) * PROD_W'(r_q);

  assign c_term[1] = TERM_W'(m_ii) + TERM_W'(m_qq);
  assign c_term[0] = TERM_W'(m_qi) - TERM_W'(m_iq);
  assign p_term[0] = TERM_W'(m_rr) + TERM_W'(m_ss);

  corr_accum #(.TERM_W(TERM_W), .WINDOW(WINDOW), .LANES(2)) u_corr (
    .clk_i(clk), .rst_i(rst), .en_i(s_acc), .term_i(c_term), .sum_o(c_sum)
  );

  corr_accum #(.TERM_W(TERM_W), .WINDOW(WINDOW), .LANES(1)) u_power (
    .clk_i(clk), .rst_i(rst), .en_i(s_acc), .term_i(p_term), .sum_o(p_sum)
  );

  // Decision uses the registered sums, so it lags the incoming sample by one acceptance.
  assign mag_re = c_sum[1][ACC_W-1] ? (~c_sum[1] + ACC_W'(1)) : c_sum[1];
  assign mag_im = c_sum[0][ACC_W-1] ? (~c_sum[0] + ACC_W'(1)) : c_sum[0];
  assign lhs    = (CMP_W'(mag_re) + CMP_W'(mag_im)) << 4;
  assign rhs    = CMP_W'(p_sum[0]) * CMP_W'(THRESH_Q4);
  assign above  = (lhs >= rhs) && (CMP_W'(p_sum[0]) >= CMP_W'(MIN_POWER));

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    last    = 1'b0;
    det_d   = 1'b0;
    if (s_acc) begin
      unique case (state_q)
        IDLE: if (above) begin
          state_d = ARMED;
          run_d   = RUN_W'(1);
        end
        ARMED: begin
          if (!above) begin
            state_d = IDLE;
            run_d   = '0;
          end else if (run_q == RUN_W'(HOLD - 1)) begin
            state_d = CAPTURE;
            run_d   = '0;
            cnt_d   = '0;
            det_d   = 1'b1;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
        CAPTURE: begin
          load = 1'b1;
          if (cnt_q == CNT_W'(CAPTURE_LEN - 1)) begin
            last    = 1'b1;
            cnt_d   = '0;
            state_d = COOLDOWN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        COOLDOWN: begin
          if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
            cnt_d   = '0;
            run_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      run_q    <= '0;
      cnt_q    <= '0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      detect_q <= det_d;
    end
  end

  // Loads only happen when the slot is free or draining this cycle, so nothing is overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (load) begin
      m_valid_q <= 1'b1;
      m_data_q  <= s00_axis.tdata;
      m_last_q  <= last;
    end else if (m00_axis.tready) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end
  end

`ifdef STF_DETECTOR_STATS_EN
  logic [15:0] det_cnt_q, drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      det_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (det_d) begin
      det_cnt_q <= det_cnt_q + 16'd1;
      if (m_valid_q && !m00_axis.tready) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign det_count  = det_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

  assign s00_axis.tready = s_ready;
  assign m00_axis.tvalid = m_valid_q;
  assign m00_axis.tdata  = m_data_q;
  assign m00_axis.tlast  = m_last_q;
  assign detect          = detect_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_stf_detector.sv
// Self-checking bench for stf_detector: table of stimulus scenarios with expected
// detection timing, plus a hand-written reset-during-capture sequence.
module tb_stf_detector;
  import wavesense_csi_pkg::*;

  typedef struct {
    int         kind;          // 0 zeros, 1 periodic, 2 periodic then noise
    int         amp;
    int         n;
    bit         bp;
    int         exp_det;
    int         exp_det_idx;
    int         exp_arm_idx;
    int         exp_beats;
    bit         ready_always;
    stf_state_e exp_state;
  } vec_t;

  localparam logic [15:0] PAT_I = 16'hA5C3;
  localparam logic [15:0] PAT_Q = 16'h3C96;

  logic       clk = 1'b0;
  logic       rst;
  logic       detect;
  stf_state_e state;
`ifdef STF_DETECTOR_STATS_EN
  logic [15:0] det_count, drop_count;
`endif

  stf_detector_if s_if ();
  stf_detector_if m_if ();

  stf_detector dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(rst),
    .s00_axis       (s_if),
    .m00_axis       (m_if),
    .detect         (detect),
`ifdef STF_DETECTOR_STATS_EN
    .det_count      (det_count),
    .drop_count     (drop_count),
`endif
    .state_o        (state)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [32:0] exp_q[$];
  int          acc_cnt, beats, last_cnt, det_cnt, det_idx, arm_idx, ready_low, stall_viol, cyc;
  logic        stalled;
  logic [32:0] held;
  logic [31:0] lfsr;
  vec_t        vecs[5];
  bit          ab;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [31:0] periodic(input int idx, input int amp);
    logic [15:0] pi, pq;
    logic signed [15:0] a, iv, qv;
    pi = PAT_I;
    pq = PAT_Q;
    a  = 16'(amp);
    iv = pi[idx % 16] ? -a : a;
    qv = pq[idx % 16] ? -a : a;
    return {iv, qv};
  endfunction

  task automatic lfsr_step();
    for (int k = 0; k < 32; k++) lfsr = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'hA300_0000 : 32'h0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_m_tvalid"}, m_if.tvalid, 0);
    check({tag, "_m_tlast"}, m_if.tlast, 0);
    check({tag, "_m_tdata"}, m_if.tdata, 0);
    check({tag, "_detect"}, detect, 0);
    check({tag, "_state"}, state, IDLE);
    check({tag, "_s_tready"}, s_if.tready, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive at negedge, observe registered outputs, then let the posedge happen.
  task automatic cycle(input logic in_valid, input logic [31:0] in_data, input bit bp,
                       output logic acc);
    @(negedge clk);
    s_if.tvalid = in_valid;
    s_if.tdata  = in_data;
    m_if.tready = bp ? (cyc % 3 != 0) : 1'b1;
    cyc++;
    #1;
    if (stalled && (!m_if.tvalid || {m_if.tlast, m_if.tdata} != held)) stall_viol++;
    if (detect) begin
      det_cnt++;
      if (det_idx < 0) det_idx = acc_cnt - 1;
    end
    if (state == ARMED && arm_idx < 0) arm_idx = acc_cnt - 1;
    if (!s_if.tready) ready_low++;
    if (m_if.tvalid && m_if.tready) begin
      beats++;
      if (m_if.tlast) last_cnt++;
      if (exp_q.size() == 0) check("beat_expected", 0, 1);
      else check("beat", {m_if.tlast, m_if.tdata}, exp_q.pop_front());
    end
    stalled = m_if.tvalid && !m_if.tready;
    held    = {m_if.tlast, m_if.tdata};
    acc     = s_if.tvalid && s_if.tready;
    if (acc) acc_cnt++;
    @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int abort_beat, output bit aborted);
    logic        acc;
    logic [31:0] d;
    int          idx, guard;
    exp_q.delete();
    acc_cnt = 0; beats = 0; last_cnt = 0; det_cnt = 0; det_idx = -1; arm_idx = -1;
    ready_low = 0; stall_viol = 0; stalled = 1'b0; held = '0; lfsr = 32'h1D2C_3B4A;
    idx = 0; guard = 0; aborted = 1'b0;
    while (idx < v.n && guard < 5000 && !aborted) begin
      if (v.kind == 0) d = '0;
      else if (v.kind == 2 && idx >= 40) d = lfsr;
      else d = periodic(idx, v.amp);
      cycle(1'b1, d, v.bp, acc);
      if (acc) begin
        if (v.exp_det > 0 && idx > v.exp_det_idx && idx <= v.exp_det_idx + v.exp_beats)
          exp_q.push_back({idx == v.exp_det_idx + v.exp_beats, d});
        if (v.kind == 2 && idx >= 40) lfsr_step();
        idx++;
      end
      if (abort_beat > 0 && beats >= abort_beat) aborted = 1'b1;
      guard++;
    end
    if (!aborted) begin
      check("samples_accepted", idx, v.n);
      guard = 0;
      while ((exp_q.size() > 0 || m_if.tvalid) && guard < 2000) begin
        cycle(1'b0, '0, v.bp, acc);
        guard++;
      end
      check("scoreboard_empty", exp_q.size(), 0);
      check("m_tvalid_drained", m_if.tvalid, 0);
      check("detect_pulses", det_cnt, v.exp_det);
      check("detect_index", det_idx, v.exp_det_idx);
      check("armed_index", arm_idx, v.exp_arm_idx);
      check("frame_beats", beats, v.exp_beats);
      check("tlast_count", last_cnt, (v.exp_beats > 0) ? 1 : 0);
      check("stall_stability", stall_viol, 0);
      if (v.ready_always) check("s_tready_low_cycles", ready_low, 0);
      check("final_state", state, v.exp_state);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    cyc = 0;
    vecs[0] = '{0, 0,    1000, 1'b0, 0, -1, -1, 0,   1'b1, IDLE};
    vecs[1] = '{1, 8000, 420,  1'b0, 1, 59, 28, 320, 1'b1, COOLDOWN};
    vecs[2] = '{1, 8000, 420,  1'b1, 1, 59, 28, 320, 1'b0, COOLDOWN};
    vecs[3] = '{2, 8000, 600,  1'b0, 0, -1, 28, 0,   1'b1, IDLE};
    vecs[4] = '{1, 100,  600,  1'b0, 0, -1, -1, 0,   1'b1, IDLE};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    reset_checks("init");

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_vec(vecs[i], 0, ab);
    end

    // Reset in the middle of a frame, then a full re-detection with unchanged timing.
    do_reset();
    run_vec(vecs[1], 100, ab);
    check("abort_reached", ab, 1);
    check("abort_beats", beats, 100);
    check("abort_no_tlast", last_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    #1;
    check("rst_s_tready", s_if.tready, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset_checks("abort");
    rst = 1'b0;
    run_vec(vecs[1], 0, ab);

`ifdef STF_DETECTOR_STATS_EN
    check("det_count", det_count, 1);
    check("drop_count", drop_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
